// File: rtl/add_normalize.sv
// Final add/subtract and normalise stage of a single-precision adder.
// Takes pre-aligned mantissas, returns a packed IEEE-754 single (truncating, no rounding).
module add_normalize (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sA,
    input  logic        sB,
    input  logic [7:0]  e,
    input  logic [23:0] mAes,
    input  logic [23:0] mBes,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_NORM = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        sa_q, sa_d;
    logic        sb_q, sb_d;
    logic [23:0] ma_q, ma_d;
    logic [23:0] mb_q, mb_d;
    logic [24:0] sum_q, sum_d;
    logic [7:0]  exp_q, exp_d;
    logic        sign_q, sign_d;
    logic [31:0] result_q, result_d;

    logic [24:0] add_sum;
    logic [23:0] diff;
    logic        a_ge_b;
    logic [7:0]  exp_inc;
    logic        norm_done;

    assign add_sum   = {1'b0, ma_q} + {1'b0, mb_q};
    assign a_ge_b    = (ma_q >= mb_q);
    assign diff      = a_ge_b ? (ma_q - mb_q) : (mb_q - ma_q);
    assign exp_inc   = exp_q + 8'd1;
    // exp <= 1 also catches a zero exponent so a left shift can never wrap it.
    assign norm_done = (sum_q == 25'd0) || sum_q[24] || sum_q[23] || (exp_q <= 8'd1);

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            ma_q     <= 24'd0;
            mb_q     <= 24'd0;
            sum_q    <= 25'd0;
            exp_q    <= 8'd0;
            sign_q   <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            sum_q    <= sum_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            result_q <= result_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (in_valid) state_d = S_ADD;
            S_ADD:  state_d = (exp_q == 8'hFF) ? S_DONE : S_NORM;
            S_NORM: if (norm_done) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        sa_d     = sa_q;
        sb_d     = sb_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        sum_d    = sum_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        result_d = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sa_d  = sA;
                    sb_d  = sB;
                    ma_d  = mAes;
                    mb_d  = mBes;
                    exp_d = e;
                end
            end
            S_ADD: begin
                if (exp_q == 8'hFF) begin
                    result_d = {sa_q, 8'hFF, 23'd0};
                end else if (sa_q == sb_q) begin
                    sum_d  = add_sum;
                    sign_d = sa_q;
                end else begin
                    sum_d  = {1'b0, diff};
                    sign_d = (ma_q == mb_q) ? 1'b0 : (a_ge_b ? sa_q : sb_q);
                end
            end
            S_NORM: begin
                if (sum_q == 25'd0) begin
                    result_d = 32'd0;
                end else if (sum_q[24]) begin
                    sum_d    = sum_q >> 1;
                    exp_d    = exp_inc;
                    result_d = (exp_inc == 8'hFF) ? {sign_q, 8'hFF, 23'd0}
                                                  : {sign_q, exp_inc, sum_q[23:1]};
                end else if (sum_q[23]) begin
                    result_d = {sign_q, exp_q, sum_q[22:0]};
                end else if (exp_q <= 8'd1) begin
                    result_d = 32'd0;
                end else begin
                    sum_d = sum_q << 1;
                    exp_d = exp_q - 8'd1;
                end
            end
            S_DONE: begin
            end
            default: begin
            end
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        result    = result_q;
        state_o   = state_q;
    end

endmodule

// File: doc/add_normalize.md
ADD_NORMALIZE -- requirements
Module: add_normalize

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  aligned operand set present on inputs.
REQ-004 in_ready  output  1  block can accept an operand set (high only in IDLE).
REQ-005 sA, sB  input  1 each  operand signs.
REQ-006 e  input  8  common biased exponent after alignment.
REQ-007 mAes, mBes  input  24 each  aligned mantissas, bit 23 = hidden bit.
REQ-008 out_valid  output  1  result holds a completed IEEE-754 single.
REQ-009 out_ready  input  1  downstream accepts result.
REQ-010 result  output  32  packed {sign, exp[7:0], frac[22:0]}.

Function
REQ-011 States SHALL be IDLE, ADD, NORM, DONE.
REQ-012 IDLE: in_ready=1; in_valid=1 at an edge captures sA, sB, e, mAes, mBes and moves to ADD; otherwise stay.
REQ-013 ADD (one cycle): sA==sB -> 25-bit sum = mAes+mBes, sign=sA; sA!=sB -> larger mantissa minus smaller, sign of larger; equal mantissas -> sum 0, sign 0; moves to NORM.
REQ-014 e==8'hFF captured -> ADD SHALL set result {sA,8'hFF,23'b0} and go directly to DONE, skipping NORM.
REQ-015 NORM, one action per cycle, priority order:
  a) sum==0 -> result 32'h00000000, go DONE;
  b) sum[24]=1 -> sum>>1 (truncate), exp+1; if new exp==255, result {sign,8'hFF,23'b0}; go DONE;
  c) sum[23]=1 -> result {sign,exp,sum[22:0]}, go DONE;
  d) exp==1 -> flush: result 32'h00000000, go DONE;
  e) else sum<<1, exp-1, stay NORM.
REQ-016 No rounding; discarded bits are truncated.
REQ-017 Latency: acceptance edge E0; out_valid SHALL be high in the cycle after edge E0+2+n, n = number of left shifts (0..23).
REQ-018 DONE: out_valid=1; result and out_valid held stable until out_ready=1 at an edge, then go IDLE.
REQ-019 in_ready SHALL be 0 in ADD, NORM, DONE; in_valid in those states is ignored (not queued).
REQ-020 out_ready in any state but DONE SHALL have no effect.
REQ-021 Exponent arithmetic 8-bit; REQ-015 rules prevent wrap (no exp below 1 or above 255).
REQ-022 Throughput: at most one operation per 4 cycles.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE, out_valid=0, result=32'h0, in_ready=1 next cycle, regardless of state.
REQ-024 rst dominates in_valid and out_ready in the same cycle; in-flight operation is discarded, no out_valid pulse.
REQ-025 Internal sum/exp/sign registers SHALL reset to 0.

Verification
REQ-026 sA=sB=0, e=127, mAes=mBes=24'h800000 -> result 32'h40000000 (2.0); out_valid after E0+2.
REQ-027 sA=0, sB=1, e=127, mAes=mBes=24'hC00000 -> result 32'h00000000, latency E0+2.
REQ-028 sA=0, sB=1, e=127, mAes=24'h800000, mBes=24'h600000 -> 2 left shifts, result 32'h3E800000 (0.25); out_valid after E0+4.
REQ-029 sA=sB=1, e=254, mAes=mBes=24'h800000 -> result 32'hFF800000 (-inf).
REQ-030 Backpressure: out_ready=0 for 5 cycles in DONE -> result, out_valid stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-031 rst pulse during NORM of REQ-028 case -> next cycle IDLE, out_valid=0, result=0, in_ready=1; new operation afterwards completes correctly.
